// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module : lsu_pkg
// Desc   : Op codes shared with the data memory, LSU FSM states, lane helpers.
// Rev    : 1.0  initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } lsu_op_e;

  // ST_MISAL is a one-cycle slot so a rejected op answers two cycles after accept
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MISAL = 3'd1,
    ST_REQ0  = 3'd2,
    ST_WAIT0 = 3'd3,
    ST_REQ1  = 3'd4,
    ST_WAIT1 = 3'd5,
    ST_RESP  = 3'd6
  } lsu_state_e;

  function automatic logic [3:0] size_mask(input lsu_op_e op);
    case (op)
      OP_LW, OP_SW:         size_mask = 4'b1111;
      OP_LH, OP_LHU, OP_SH: size_mask = 4'b0011;
      default:              size_mask = 4'b0001;
    endcase
  endfunction

  function automatic logic is_store(input lsu_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input lsu_op_e op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:         is_misaligned = (off != 2'b00);
      OP_LH, OP_LHU, OP_SH: is_misaligned = off[0];
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module : lsu_align
// Desc   : Combinational lane logic: byte enables, store shift, load extract.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_e     op,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be_lo,
  output logic [3:0]  be_hi,
  output logic        crosses,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] load_data
);

  logic [7:0]  be64;
  logic [63:0] wdata64;
  logic [63:0] rdata64;
  logic [5:0]  shamt;

  always_comb begin
    shamt   = {offset, 3'b000};
    be64    = {4'b0000, size_mask(op)} << offset;
    wdata64 = {32'd0, wdata} << shamt;
    rdata64 = {rdata_hi, rdata_lo} >> shamt;
    case (op)
      OP_LH:   load_data = {{16{rdata64[15]}}, rdata64[15:0]};
      OP_LHU:  load_data = {16'd0, rdata64[15:0]};
      OP_LB:   load_data = {{24{rdata64[7]}}, rdata64[7:0]};
      OP_LBU:  load_data = {24'd0, rdata64[7:0]};
      default: load_data = rdata64[31:0];
    endcase
  end

  assign be_lo    = be64[3:0];
  assign be_hi    = be64[7:4];
  assign crosses  = |be64[7:4];
  assign wdata_lo = wdata64[31:0];
  assign wdata_hi = wdata64[63:32];

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module : lsu_mem_master
// Desc   : Single-outstanding load/store initiator to word-addressed memory.
//          LSU_MISALIGN_SPLIT_EN: allow misaligned ops, split word-crossers.
// Rev    : 1.0  initial release
// ============================================================================
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid,
  output logic              core_ready,
  input  logic [2:0]        core_op,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  lsu_state_e        state_q, state_d;
  lsu_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]  be_lo, be_hi;
  logic        crosses, misaligned, timed_out, in_req, beat1, store;
  logic [31:0] wdata_lo, wdata_hi, load_data;

  lsu_align u_align (
    .op        (op_q),
    .offset    (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata_lo  (rdata0_q),
    .rdata_hi  (rdata1_q),
    .be_lo     (be_lo),
    .be_hi     (be_hi),
    .crosses   (crosses),
    .wdata_lo  (wdata_lo),
    .wdata_hi  (wdata_hi),
    .load_data (load_data)
  );

`ifdef LSU_MISALIGN_SPLIT_EN
  assign misaligned = 1'b0;
`else
  assign misaligned = is_misaligned(lsu_op_e'(core_op), core_addr[1:0]);
`endif

  assign timed_out = (TIMEOUT_CYC != 0) && (32'(cnt_q) == 32'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err_d    = err_q;
    cnt_d    = cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (core_valid) begin
          op_d     = lsu_op_e'(core_op);
          addr_d   = core_addr;
          wdata_d  = core_wdata;
          rdata0_d = '0;
          rdata1_d = '0;
          err_d    = misaligned;
          cnt_d    = '0;
          state_d  = misaligned ? ST_MISAL : ST_REQ0;
        end
      end
      ST_MISAL: state_d = ST_RESP;
      ST_REQ0, ST_REQ1: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = (state_q == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WAIT0: begin
        if (mem_rvalid) begin
          rdata0_d = mem_rdata;
          cnt_d    = '0;
          // Aligned ops never cross, so REQ1 is only reachable in split builds
          state_d  = crosses ? ST_REQ1 : ST_RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_WAIT1: begin
        if (mem_rvalid) begin
          rdata1_d = mem_rdata;
          state_d  = ST_RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_LW;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are gated by rst so everything reads 0 while reset is held
  assign in_req = ((state_q == ST_REQ0) || (state_q == ST_REQ1)) && !rst;
  assign beat1  = (state_q == ST_REQ1);
  assign store  = is_store(op_q);

  assign core_ready = (state_q == ST_IDLE) && !rst;
  assign mem_req    = in_req;
  assign mem_we     = in_req && store;
  assign mem_be     = in_req ? (beat1 ? be_hi : be_lo) : 4'b0000;
  assign mem_addr   = in_req ? {addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, beat1}, 2'b00}
                             : '0;
  assign mem_wdata  = (in_req && store) ? (beat1 ? wdata_hi : wdata_lo) : 32'd0;

  assign rsp_valid  = (state_q == ST_RESP) && !rst;
  assign rsp_err    = rsp_valid && err_q;
  assign rsp_rdata  = (rsp_valid && !err_q && !store) ? load_data : 32'd0;

endmodule
`default_nettype wire
